// File: rtl/ax301_segment_scan.sv
// Multiplexed 7-segment scanner for the AX301 board: time-slices DIGITS common-anode digits,
// with a dead-time blank at the start of each slot and a per-frame snapshot of the inputs.
package ax301_peripherals_pkg;
    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] segment;
    } ax301_segment_ctrl;
endpackage

module ax301_segment_scan #(
    parameter int DIGITS       = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic                                     hex_mode,
    input  logic [DIGITS-1:0][7:0]                   digit_data,
    input  logic [DIGITS-1:0]                        digit_mask,
    output ax301_peripherals_pkg::ax301_segment_ctrl seg_ctrl,
    output logic                                     frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    // Every slot opens in BLANK unless there is no dead time at all.
    localparam logic [1:0] S_SLOT0 = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0][7:0] snap_data_q, snap_data_d;
    logic [DIGITS-1:0]      snap_mask_q, snap_mask_d;
    logic                   snap_hex_q, snap_hex_d;
    logic                   take;

    ax301_peripherals_pkg::ax301_segment_ctrl seg_q, seg_d;
    logic                                     fs_q;
    logic [7:0]                               pat;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_mask_d = snap_mask_q;
        snap_hex_d  = snap_hex_q;
        take        = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SLOT0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    take    = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
                end
                S_DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SLOT0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            take  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
        if (take) begin
            snap_data_d = digit_data;
            snap_mask_d = digit_mask;
            snap_hex_d  = hex_mode;
        end
    end

    // Outputs are computed from next-state values so the registered pins line up with the FSM.
    always_comb begin
        pat   = snap_hex_d ? {snap_data_d[idx_d][7], hex7(snap_data_d[idx_d][3:0])}
                           : snap_data_d[idx_d];
        seg_d = '1;
        if (state_d == S_DRIVE && snap_mask_d[idx_d]) begin
            seg_d.sel     = ~(6'd1 << idx_d);
            seg_d.segment = ~pat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_data_q <= '0;
            snap_mask_q <= '0;
            snap_hex_q  <= 1'b0;
            seg_q       <= '1;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_mask_q <= snap_mask_d;
            snap_hex_q  <= snap_hex_d;
            seg_q       <= seg_d;
            fs_q        <= take;
        end
    end

    assign seg_ctrl    = seg_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_ax301_segment_scan.sv
// Scoreboard bench: a slot/frame timing model pushes the expected pins per cycle,
// and each scenario pops and compares them against the scanner outputs.
module tb_ax301_segment_scan;
    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = SD * 6;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic       fs;
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst, en, en0, hex_mode;
    logic [5:0][7:0]      digit_data;
    logic [5:0]           digit_mask;
    ax301_peripherals_pkg::ax301_segment_ctrl seg_ctrl, seg_ctrl0;
    logic                 frame_start, frame_start0;

    logic [5:0][7:0]      sn_data;
    logic [5:0]           sn_mask;
    logic                 sn_hex;
    exp_t                 sb[$];
    int                   n_tests = 0;
    int                   n_fail  = 0;

    always #5 clk = ~clk;

    ax301_segment_scan #(.DIGITS(6), .SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .hex_mode(hex_mode), .digit_data(digit_data),
        .digit_mask(digit_mask), .seg_ctrl(seg_ctrl), .frame_start(frame_start)
    );

    ax301_segment_scan #(.DIGITS(6), .SCAN_DIV(SD), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .hex_mode(hex_mode), .digit_data(digit_data),
        .digit_mask(digit_mask), .seg_ctrl(seg_ctrl0), .frame_start(frame_start0)
    );

    // Expected pins for cycle t after enable; the frame snapshot is the inputs present at frame start.
    task automatic push_exp(input int t, input int bl);
        exp_t e;
        int pos, id;
        logic [7:0] p;
        if (t % FRAME == 0) begin
            sn_data = digit_data;
            sn_mask = digit_mask;
            sn_hex  = hex_mode;
        end
        pos   = t % SD;
        id    = (t / SD) % 6;
        e.fs  = (t % FRAME == 0);
        e.sel = 6'h3F;
        e.seg = 8'hFF;
        if (pos >= bl && sn_mask[id]) begin
            p     = sn_hex ? {sn_data[id][7], HEX[sn_data[id][3:0]]} : sn_data[id];
            e.sel = ~(6'd1 << id);
            e.seg = ~p;
        end
        sb.push_back(e);
    endtask

    task automatic push_off();
        sb.push_back(15'h3FFF);
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; en0 = 1'b1;
        sb.delete();
        push_off();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e || {frame_start0, seg_ctrl0} !== e) begin
                n_fail++;
                $display("FAIL reset k=%0d got=%h/%h exp=%h", k, {frame_start, seg_ctrl},
                         {frame_start0, seg_ctrl0}, e);
            end
            if (k == 2) begin rst = 1'b0; en = 1'b0; en0 = 1'b0; end
            push_off();
        end
    endtask

    task automatic test_hex_basic();
        exp_t e;
        restart();
        digit_data = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        digit_mask = 6'h3F; hex_mode = 1'b1; en = 1'b1;
        push_exp(0, BL);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL hex_basic t=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            n_tests++;
            if ($countones(~seg_ctrl.sel) > 1) begin
                n_fail++;
                $display("FAIL one_sel t=%0d got sel=%h exp at most one low bit", k, seg_ctrl.sel);
            end
            push_exp(k + 1, BL);
        end
    endtask

    task automatic test_raw();
        exp_t e;
        restart();
        digit_data = {8'h3C, 8'h00, 8'hFF, 8'hA5, 8'h42, 8'h81};
        digit_mask = 6'h3F; hex_mode = 1'b0; en = 1'b1;
        push_exp(0, BL);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL raw t=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            push_exp(k + 1, BL);
        end
    endtask

    task automatic test_mask();
        exp_t e;
        restart();
        digit_data = {8'h0F, 8'h8E, 8'h09, 8'h08, 8'h86, 8'h8A};
        digit_mask = 6'b111110; hex_mode = 1'b1; en = 1'b1;
        push_exp(0, BL);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL mask t=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            push_exp(k + 1, BL);
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        restart();
        digit_data = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        digit_mask = 6'h3F; hex_mode = 1'b1; en = 1'b1;
        push_exp(0, BL);
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL snapshot t=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            if (k == 26) digit_data[0] = 8'h87;
            push_exp(k + 1, BL);
        end
    endtask

    task automatic test_hex_table();
        exp_t e;
        restart();
        digit_data = {8'h8F, 8'h0E, 8'h8D, 8'h0C, 8'h8B, 8'h0A};
        digit_mask = 6'h3F; hex_mode = 1'b1; en = 1'b1;
        push_exp(0, BL);
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL hex_table t=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            if (k == 30) digit_data = {8'h09, 8'h88, 8'h07, 8'h86, 8'h01, 8'h02};
            if (k == 70) hex_mode = 1'b0;
            push_exp(k + 1, BL);
        end
    endtask

    task automatic test_disable_reset();
        exp_t e;
        int t;
        restart();
        digit_data = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        digit_mask = 6'h3F; hex_mode = 1'b1; en = 1'b1;
        t = 0;
        push_exp(0, BL);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start, seg_ctrl} !== e) begin
                n_fail++;
                $display("FAIL disable_reset k=%0d got=%h exp=%h", k, {frame_start, seg_ctrl}, e);
            end
            case (k)
                11: en = 1'b0;
                14: begin en = 1'b1; digit_data[0] = 8'h0F; end
                26: rst = 1'b1;
                28: rst = 1'b0;
                default: ;
            endcase
            if (rst || !en) begin
                push_off();
                t = -1;
            end else begin
                t = t + 1;
                push_exp(t, BL);
            end
        end
    endtask

    task automatic test_no_blank();
        exp_t e;
        restart();
        digit_data = {8'h15, 8'h84, 8'h03, 8'h02, 8'h81, 8'h00};
        digit_mask = 6'h3F; hex_mode = 1'b1; en0 = 1'b1;
        push_exp(0, 0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({frame_start0, seg_ctrl0} !== e) begin
                n_fail++;
                $display("FAIL no_blank t=%0d got=%h exp=%h", k, {frame_start0, seg_ctrl0}, e);
            end
            n_tests++;
            if ($countones(~seg_ctrl0.sel) > 1) begin
                n_fail++;
                $display("FAIL no_blank_one_sel t=%0d got sel=%h exp at most one low bit", k,
                         seg_ctrl0.sel);
            end
            push_exp(k + 1, 0);
        end
        en0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en0 = 1'b0; hex_mode = 1'b0;
        digit_data = '0; digit_mask = '0;
        sn_data = '0; sn_mask = '0; sn_hex = 1'b0;
        test_reset();
        test_hex_basic();
        test_raw();
        test_mask();
        test_snapshot();
        test_hex_table();
        test_disable_reset();
        test_no_blank();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, tests run=%0d", n_tests);
        $fatal(1);
    end
endmodule
